// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects,
// memory wait-state FSM states and the architectural PC register number.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [3:0] R15 = 4'hF;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding compare for one Execute source register.
// Memory stage wins over Writeback; the PC (R15) is never forwarded.
module hazard_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [3:0] ra,
  input  logic [3:0] wa3m,
  input  logic [3:0] wa3w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    fwd = FWD_RF;
    if (ra != R15) begin
      if (reg_write_m && (wa3m == ra))      fwd = FWD_M;
      else if (reg_write_w && (wa3w == ra)) fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding,
// stage stall/flush enables, data-memory wait states with timeout, statistics.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemAccessM,
  input  logic             MemReady,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemError,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MEM_TIMEOUT);

  mem_state_t       state, state_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic [1:0]       fwd_a, fwd_b;
  logic             ldrstall, pcpend, memstall, set_error, branch_flush;

  hazard_fwd_unit u_fwd_a (
    .ra(RA1E), .wa3m(WA3M), .wa3w(WA3W),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(fwd_a)
  );

  hazard_fwd_unit u_fwd_b (
    .ra(RA2E), .wa3m(WA3M), .wa3w(WA3W),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(fwd_b)
  );

  assign ForwardAE = reset ? FWD_RF : fwd_a;
  assign ForwardBE = reset ? FWD_RF : fwd_b;

  assign ldrstall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
  assign pcpend   = PCSrcD || PCSrcE || PCSrcM;

  always_comb begin
    state_next = state;
    timer_next = timer;
    memstall   = 1'b0;
    case (state)
      S_IDLE: begin
        if (MemAccessM && !MemReady) begin
          state_next = S_WAIT;
          timer_next = TMR_W'(1);
          memstall   = 1'b1;
        end
      end
      S_WAIT: begin
        if (MemReady) begin
          state_next = S_IDLE;
          timer_next = '0;
        end else begin
          memstall = 1'b1;
          if (timer != TMR_MAX) timer_next = timer + TMR_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        timer_next = '0;
      end
    endcase
  end

  assign set_error = (state == S_WAIT) && (timer == TMR_MAX);

  // A memory stall freezes everything up to M and bubbles W; the frozen
  // D/E registers re-raise any load-use or branch hazard once it clears.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!reset) begin
      if (memstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = ldrstall || pcpend;
        StallD = ldrstall;
        FlushD = pcpend || PCSrcW || BranchTakenE;
        FlushE = ldrstall || BranchTakenE;
      end
    end
  end

  assign branch_flush = FlushE && BranchTakenE;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      MemError   <= 1'b0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      if (set_error) MemError <= 1'b1;
      if (StallF && (StallCount != '1)) StallCount <= StallCount + CNT_W'(1);
      if (branch_flush && (FlushCount != '1)) FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a reference model queues expected outputs
// as each cycle is driven; each scenario task pops and compares them.
module tb_hazard_ctrl;

  localparam int MT = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic          RegWriteM, RegWriteW, MemtoRegE;
  logic          PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemAccessM, MemReady;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemError;
  logic [CW-1:0] StallCount, FlushCount;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemAccessM(MemAccessM), .MemReady(MemReady),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemError(MemError), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  typedef struct packed {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic rwm, rww, m2r, pcd, pce, pcm, pcw, bte, mam, mrdy;
  } stim_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic sf, sd, se, sm, fd, fe, fw, err;
    logic [CW-1:0] sc, fc;
  } obs_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  obs_t  exp_q[$];
  obs_t  got, want;
  stim_t last_stim;

  bit m_wait, m_err;
  int m_timer, m_sc, m_fc;

  task automatic model_init();
    m_wait = 0; m_err = 0; m_timer = 0; m_sc = 0; m_fc = 0;
  endtask

  function automatic logic [1:0] ref_fwd(logic [3:0] ra, stim_t s);
    if (ra == 4'hF)                 return 2'b00;
    if (s.rwm && s.wa3m == ra)      return 2'b10;
    if (s.rww && s.wa3w == ra)      return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_memstall(stim_t s);
    return m_wait ? !s.mrdy : (s.mam && !s.mrdy);
  endfunction

  function automatic obs_t ref_out(stim_t s);
    obs_t o = '0;
    bit ldr = s.m2r && (s.wa3e == s.ra1d || s.wa3e == s.ra2d);
    bit pcp = s.pcd || s.pce || s.pcm;
    o.fa = ref_fwd(s.ra1e, s);
    o.fb = ref_fwd(s.ra2e, s);
    if (ref_memstall(s)) begin
      {o.sf, o.sd, o.se, o.sm, o.fw} = 5'b11111;
    end else begin
      o.sf = ldr || pcp;
      o.sd = ldr;
      o.fd = pcp || s.pcw || s.bte;
      o.fe = ldr || s.bte;
    end
    o.err = m_err;
    o.sc  = CW'(m_sc);
    o.fc  = CW'(m_fc);
    return o;
  endfunction

  task automatic model_step(stim_t s);
    obs_t o = ref_out(s);
    if (o.sf && m_sc < (1 << CW) - 1) m_sc++;
    if (s.bte && o.fe && m_fc < (1 << CW) - 1) m_fc++;
    if (m_wait && m_timer == MT) m_err = 1;
    if (!m_wait) begin
      if (s.mam && !s.mrdy) begin m_wait = 1; m_timer = 1; end
    end else if (s.mrdy) begin
      m_wait = 0; m_timer = 0;
    end else if (m_timer < MT) begin
      m_timer++;
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.fa = ForwardAE; o.fb = ForwardBE;
    o.sf = StallF; o.sd = StallD; o.se = StallE; o.sm = StallM;
    o.fd = FlushD; o.fe = FlushE; o.fw = FlushW; o.err = MemError;
    o.sc = StallCount; o.fc = FlushCount;
    return o;
  endfunction

  task automatic drive(stim_t s);
    RA1D = s.ra1d; RA2D = s.ra2d; RA1E = s.ra1e; RA2E = s.ra2e;
    WA3E = s.wa3e; WA3M = s.wa3m; WA3W = s.wa3w;
    RegWriteM = s.rwm; RegWriteW = s.rww; MemtoRegE = s.m2r;
    PCSrcD = s.pcd; PCSrcE = s.pce; PCSrcM = s.pcm; PCSrcW = s.pcw;
    BranchTakenE = s.bte; MemAccessM = s.mam; MemReady = s.mrdy;
  endtask

  // Advance the model across the edge, drive the next stimulus, queue its
  // expectation and stop at the falling edge where outputs are sampled.
  task automatic cycle(stim_t s);
    @(posedge clk);
    model_step(last_stim);
    #1;
    drive(s);
    last_stim = s;
    exp_q.push_back(ref_out(s));
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive('0);
    last_stim = '0;
    model_init();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stim_t s = '0;
    reset = 1'b1;
    s.m2r = 1; s.wa3e = 4'd5; s.ra1d = 4'd5; s.bte = 1; s.pcd = 1;
    s.rwm = 1; s.wa3m = 4'd3; s.ra1e = 4'd3; s.ra2e = 4'd3; s.mam = 1;
    drive(s);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = observe();
      n_cmp++;
      if (got !== '0) begin
        n_bad++;
        $display("FAIL reset[%0d] got=%h want=%h", i, got, obs_t'('0));
      end
    end
    drive('0);
    last_stim = '0;
    model_init();
    reset = 1'b0;
  endtask

  task automatic test_forward();
    logic [1:0] plan_fa[3] = '{2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 6; i++) begin
      stim_t s = '0;
      s.rwm = 1; s.rww = 1; s.wa3m = 4'd3; s.wa3w = 4'd3; s.ra1e = 4'd3; s.ra2e = 4'd7;
      case (i)
        1: s.rwm = 0;
        2: s.ra1e = 4'hF;
        3: begin s.wa3m = 4'hF; s.wa3w = 4'hF; s.ra1e = 4'hF; s.ra2e = 4'hF; end
        4: begin s.ra2e = 4'd3; s.wa3w = 4'd9; end
        5: begin s.ra1e = 4'd9; s.ra2e = 4'd3; s.wa3m = 4'd4; s.wa3w = 4'd9; end
        default: ;
      endcase
      cycle(s);
      got = observe();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL forward[%0d] got=%h want=%h", i, got, want);
      end
      if (i < 3) begin
        n_cmp++;
        if (got.fa !== plan_fa[i]) begin
          n_bad++;
          $display("FAIL forward_a_plan[%0d] got=%b want=%b", i, got.fa, plan_fa[i]);
        end
      end
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      stim_t s = '0;
      if (i == 0) begin s.m2r = 1; s.wa3e = 4'd5; s.ra2d = 4'd5; s.ra1d = 4'd2; end
      cycle(s);
      got = observe();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL load_use[%0d] got=%h want=%h", i, got, want);
      end
    end
    n_cmp++;
    if (got.sc !== CW'(1) || got.sf !== 1'b0) begin
      n_bad++;
      $display("FAIL load_use_count got sc=%0d sf=%b want sc=1 sf=0", got.sc, got.sf);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      stim_t s = '0;
      case (i)
        0: s.bte = 1;
        2: s.pcd = 1;
        3: s.pcw = 1;
        4: s.pcm = 1;
        5: begin s.bte = 1; s.m2r = 1; s.wa3e = 4'd6; s.ra1d = 4'd6; end
        default: ;
      endcase
      cycle(s);
      got = observe();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL branch[%0d] got=%h want=%h", i, got, want);
      end
      if (i == 5) begin
        n_cmp++;
        if ({got.fe, got.sd, got.fd} !== 3'b111) begin
          n_bad++;
          $display("FAIL branch_ldr_plan got fe/sd/fd=%b want 111", {got.fe, got.sd, got.fd});
        end
      end
    end
    n_cmp++;
    if (got.fc !== CW'(2)) begin
      n_bad++;
      $display("FAIL branch_flush_count got=%0d want=2", got.fc);
    end
  endtask

  task automatic test_mem_wait();
    int stalls = 0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      stim_t s = '0;
      s.mam  = (i < 4);
      s.mrdy = (i == 3);
      s.bte  = (i == 5);
      cycle(s);
      got = observe();
      want = exp_q.pop_front();
      if (got.sm && got.se && got.sd && got.sf && got.fw) stalls++;
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL mem_wait[%0d] got=%h want=%h", i, got, want);
      end
    end
    n_cmp++;
    if (stalls != 3) begin
      n_bad++;
      $display("FAIL mem_wait_len got=%0d want=3", stalls);
    end
  endtask

  task automatic test_timeout();
    int first_err = -1;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      stim_t s = '0;
      s.mam  = (i != 8);
      s.mrdy = (i == 7);
      cycle(s);
      got = observe();
      want = exp_q.pop_front();
      if (got.err && first_err < 0) first_err = i;
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL timeout[%0d] got=%h want=%h", i, got, want);
      end
    end
    n_cmp++;
    if (first_err != 5 || got.err !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_err first=%0d now=%b want first=5 now=1", first_err, got.err);
    end
    reset = 1'b1;
    #1;
    got = observe();
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_wait got=%h want=%h", got, obs_t'('0));
    end
    drive('0);
    last_stim = '0;
    model_init();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle('0);
    got = observe();
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL after_reset got=%h want=%h", got, want);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 21; i++) begin
      stim_t s = '0;
      if (i < 20) begin s.m2r = 1; s.wa3e = 4'd8; s.ra1d = 4'd8; end
      cycle(s);
      got = observe();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL saturate[%0d] got=%h want=%h", i, got, want);
      end
    end
    n_cmp++;
    if (got.sc !== CW'(15)) begin
      n_bad++;
      $display("FAIL saturate_final got=%0d want=15", got.sc);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      stim_t s = '0;
      s.mam  = (i < 6);
      s.mrdy = (i < 3) || (i == 5);
      s.bte  = (i == 1) || (i == 4) || (i == 5);
      if (i >= 4 && i <= 5) begin s.m2r = 1; s.wa3e = 4'd2; s.ra2d = 4'd2; end
      cycle(s);
      got = observe();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, want);
      end
      if (i == 4) begin
        n_cmp++;
        if ({got.fe, got.fd, got.sm} !== 3'b001) begin
          n_bad++;
          $display("FAIL masked_hazard got fe/fd/sm=%b want 001", {got.fe, got.fd, got.sm});
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
